stop_frame_checker: RTL and testbench
=====================================

Name: stop_frame_checker

Overview:
Parametrised successor to the single-bit stop checker in the UART RX path. It validates 1..STOP_MAX stop bits per frame, selected at run time, and reports a registered finish/error pulse to the RX FSM. It also flags break frames (all-zero data plus failed stop) and keeps a sticky error flag and a saturating error counter for status readback. It sits between the data sampler and the RX FSM, alongside the parity checker.

Parameters:
STOP_MAX, 2, maximum stop bits per frame (>=1)
ERR_CNT_W, 8, width of the saturating stop-error counter

Ports:
StpFrm_CLK  in  1  system clock, rising edge
StpFrm_RST  in  1  reset, asynchronous, active-high
StpFrm_stp_chk_en  in  1  RX FSM in stop phase; held high for the whole stop phase
StpFrm_stop_num  in  $clog2(STOP_MAX+1)  requested stop bits; captured on the first valid sample of a frame
StpFrm_sample  in  1  majority-voted bit from the sampler
StpFrm_Sample_Valid  in  1  one-cycle strobe, sample is valid
StpFrm_data_zero  in  1  deserialiser reports all data bits 0; sampled together with the last stop sample
StpFrm_err_clr  in  1  synchronous clear of the sticky flag and counter
StpFrm_stp_err  out  1  stop error, valid only while finish=1
StpFrm_finish  out  1  one-cycle pulse, stop phase complete
StpFrm_break  out  1  one-cycle pulse with finish, break frame detected
StpFrm_err_sticky  out  1  set on any stop error, cleared only by err_clr or reset
StpFrm_err_cnt  out  ERR_CNT_W  count of frames with a stop error, saturating

Behaviour:
- Reset (async, active-high): FSM=IDLE, bit counter=0, err accumulator=0.
- Reset values of outputs: finish=0, stp_err=0, break=0, err_sticky=0, err_cnt=0.
- Effective stop count N: stop_num==0 gives N=1; stop_num>STOP_MAX gives N=STOP_MAX; otherwise N=stop_num.
- N is latched on the first valid sample and ignored afterwards.
- FSM states: IDLE, CHECK, REPORT.
- IDLE: on en & Sample_Valid:
  - latch N, set cnt=1, acc=~sample.
  - If N==1, latch brk=data_zero & ~sample and go to REPORT.
  - Otherwise go to CHECK.
- CHECK: on en & Sample_Valid:
  - cnt+=1, acc|=~sample.
  - When cnt+1==N, latch brk=data_zero & (acc|~sample) and go to REPORT.
  - Cycles with no valid strobe hold state.
- REPORT (exactly one cycle):
  - finish=1, stp_err=acc, break=brk.
  - If acc: err_sticky<=1 and err_cnt<=err_cnt+1, saturating at all-ones (no wrap).
  - Next state is IDLE unconditionally. A Sample_Valid arriving in REPORT is ignored.
- Latency: finish rises in the cycle after the clock edge that sampled the last valid stop bit (one registered stage). All outputs are registered.
- Abort: en low in CHECK returns to IDLE with no finish, no counter update and the accumulator cleared. en low in IDLE means nothing happens.
- err_clr is synchronous:
  - clears err_sticky and err_cnt.
  - If it coincides with a REPORT error, the clear wins: both end at 0.
  - Has no effect on the FSM or on the pulses.
- Outside REPORT: finish, stp_err and break are 0.
- break implies stp_err in the same cycle.
- Reset asserted mid-frame returns immediately to reset values. No pulse is produced for the interrupted frame.

Decomposition:
- Shared UART package holds:
  - FSM state encoding constants (IDLE/CHECK/REPORT).
  - STOP_MAX default.
  - A clamp function for the stop count, reused by the TX stop generator.
- One natural sub-module: sat_counter (parametrised width; inc, clr with clr priority, async active-high reset). It is reused by the parity-error counter.
- FSM and accumulator stay in the top module.

Test Plan:
- N=1 (stop_num=1), one valid sample=1 -> finish=1 for one cycle, stp_err=0, break=0, err_cnt stays 0.
- stop_num=2, samples 1 then 0 with 3 idle cycles between strobes -> no finish after the first strobe; finish=1 and stp_err=1 one cycle after the second; err_sticky=1, err_cnt=1.
- stop_num=2, samples 0,0 with data_zero=1 -> finish=1, stp_err=1, break=1 together; err_cnt increments.
- stop_num=3 (>STOP_MAX=2) and stop_num=0 -> clamped to 2 and 1 respectively; finish arrives after 2 and 1 strobes.
- stop_num=2, one valid sample, then en drops -> FSM back in IDLE, no finish, counter unchanged; the next frame checks normally.
- Preload err_cnt to 255 (ERR_CNT_W=8) and send an error frame -> stays 255. err_clr in the same cycle as an error REPORT -> err_cnt=0, err_sticky=0. Assert StpFrm_RST mid-CHECK -> all outputs 0 immediately.

Source files
------------

// File: rtl/stop_frame_checker_pkg.sv
// Shared UART definitions: stop-checker FSM encoding, the default stop-bit
// limit and the stop-count clamp that the TX stop generator also uses.
package stop_frame_checker_pkg;

   localparam int STOP_MAX_DEF = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      REPORT = 2'd2
   } stop_state_t;

   // A request of zero still means one stop bit; anything above the limit saturates.
   function automatic int unsigned clamp_stop(input int unsigned req, input int unsigned max_stop);
      if (req == 0) begin
         return 1;
      end else if (req > max_stop) begin
         return max_stop;
      end
      return req;
   endfunction

endpackage

// File: rtl/stop_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Shared by the stop-error and parity-error status counters.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/stop_frame_checker.sv
// Stop-bit checker for the UART RX path: validates 1..STOP_MAX stop bits,
// reports a registered finish/error/break pulse and keeps error status.
module stop_frame_checker
   import stop_frame_checker_pkg::*;
#(
   parameter int STOP_MAX  = STOP_MAX_DEF,
   parameter int ERR_CNT_W = 8
) (
   input  logic                           StpFrm_CLK,
   input  logic                           StpFrm_RST,
   input  logic                           StpFrm_stp_chk_en,
   input  logic [$clog2(STOP_MAX+1)-1:0]  StpFrm_stop_num,
   input  logic                           StpFrm_sample,
   input  logic                           StpFrm_Sample_Valid,
   input  logic                           StpFrm_data_zero,
   input  logic                           StpFrm_err_clr,
   output logic                           StpFrm_stp_err,
   output logic                           StpFrm_finish,
   output logic                           StpFrm_break,
   output logic                           StpFrm_err_sticky,
   output logic [ERR_CNT_W-1:0]           StpFrm_err_cnt
);

   localparam int SNW = $clog2(STOP_MAX + 1);

   stop_state_t    state, state_nx;
   logic [SNW-1:0] n_lat, n_nx;
   logic [SNW-1:0] cnt, cnt_nx;
   logic [SNW-1:0] n_req;
   logic           acc, acc_nx;
   logic           brk, brk_nx;
   logic           strobe;
   logic           finish_q, stp_err_q, break_q, sticky_q;
   logic           err_inc;

   assign n_req  = SNW'(clamp_stop(32'(StpFrm_stop_num), STOP_MAX));
   assign strobe = StpFrm_stp_chk_en & StpFrm_Sample_Valid;

   always_comb begin
      state_nx = state;
      n_nx     = n_lat;
      cnt_nx   = cnt;
      acc_nx   = acc;
      brk_nx   = brk;
      unique case (state)
         IDLE: begin
            if (strobe) begin
               n_nx   = n_req;
               cnt_nx = SNW'(1);
               acc_nx = ~StpFrm_sample;
               if (n_req == SNW'(1)) begin
                  brk_nx   = StpFrm_data_zero & ~StpFrm_sample;
                  state_nx = REPORT;
               end else begin
                  state_nx = CHECK;
               end
            end
         end
         CHECK: begin
            // Losing enable mid-frame abandons the frame without a report.
            if (!StpFrm_stp_chk_en) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               acc_nx   = 1'b0;
            end else if (StpFrm_Sample_Valid) begin
               cnt_nx = cnt + SNW'(1);
               acc_nx = acc | ~StpFrm_sample;
               if (cnt_nx == n_lat) begin
                  brk_nx   = StpFrm_data_zero & acc_nx;
                  state_nx = REPORT;
               end
            end
         end
         REPORT: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            acc_nx   = 1'b0;
            brk_nx   = 1'b0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            acc_nx   = 1'b0;
            brk_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge StpFrm_CLK or posedge StpFrm_RST) begin
      if (StpFrm_RST) begin
         state <= IDLE;
         n_lat <= SNW'(1);
         cnt   <= '0;
         acc   <= 1'b0;
         brk   <= 1'b0;
      end else begin
         state <= state_nx;
         n_lat <= n_nx;
         cnt   <= cnt_nx;
         acc   <= acc_nx;
         brk   <= brk_nx;
      end
   end

   // Pulses are loaded on entry to REPORT so they are flop outputs during it.
   always_ff @(posedge StpFrm_CLK or posedge StpFrm_RST) begin
      if (StpFrm_RST) begin
         finish_q  <= 1'b0;
         stp_err_q <= 1'b0;
         break_q   <= 1'b0;
      end else begin
         finish_q  <= (state_nx == REPORT);
         stp_err_q <= (state_nx == REPORT) & acc_nx;
         break_q   <= (state_nx == REPORT) & brk_nx;
      end
   end

   assign err_inc = finish_q & stp_err_q;

   always_ff @(posedge StpFrm_CLK or posedge StpFrm_RST) begin
      if (StpFrm_RST) begin
         sticky_q <= 1'b0;
      end else if (StpFrm_err_clr) begin
         sticky_q <= 1'b0;
      end else if (err_inc) begin
         sticky_q <= 1'b1;
      end
   end

   sat_counter #(
      .WIDTH (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (StpFrm_CLK),
      .rst   (StpFrm_RST),
      .inc   (err_inc),
      .clr   (StpFrm_err_clr),
      .count (StpFrm_err_cnt)
   );

   assign StpFrm_finish     = finish_q;
   assign StpFrm_stp_err    = stp_err_q;
   assign StpFrm_break      = break_q;
   assign StpFrm_err_sticky = sticky_q;

endmodule

// File: tb/tb_stop_frame_checker.sv
// Directed self-checking bench for stop_frame_checker with a scoreboard of
// expected report pulses and a small model of the error status.
module tb_stop_frame_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] stop_num = 2'd0;
   logic       sample = 1'b1;
   logic       valid = 1'b0;
   logic       data_zero = 1'b0;
   logic       err_clr = 1'b0;
   logic       stp_err, finish, brk_out, err_sticky;
   logic [7:0] err_cnt;

   int n_assert = 0;
   int n_fail = 0;

   typedef struct {
      logic err;
      logic brk;
   } exp_t;
   exp_t sb[$];

   int   exp_cnt = 0;
   logic exp_sticky = 1'b0;

   always #5 clk = ~clk;

   stop_frame_checker #(
      .STOP_MAX  (2),
      .ERR_CNT_W (8)
   ) dut (
      .StpFrm_CLK          (clk),
      .StpFrm_RST          (rst),
      .StpFrm_stp_chk_en   (en),
      .StpFrm_stop_num     (stop_num),
      .StpFrm_sample       (sample),
      .StpFrm_Sample_Valid (valid),
      .StpFrm_data_zero    (data_zero),
      .StpFrm_err_clr      (err_clr),
      .StpFrm_stp_err      (stp_err),
      .StpFrm_finish       (finish),
      .StpFrm_break        (brk_out),
      .StpFrm_err_sticky   (err_sticky),
      .StpFrm_err_cnt      (err_cnt)
   );

   function automatic int model_clamp(input logic [1:0] s);
      if (s == 2'd0) return 1;
      if (s > 2'd2) return 2;
      return int'(s);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the strobe is captured by the following rising edge.
   task automatic send_bit(input logic b, input logic dz);
      valid     = 1'b1;
      sample    = b;
      data_zero = dz;
      @(negedge clk);
      valid     = 1'b0;
      sample    = 1'b1;
      data_zero = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check_output({tag, "_finish"}, 32'(finish), 32'd0);
      check_output({tag, "_stp_err"}, 32'(stp_err), 32'd0);
      check_output({tag, "_break"}, 32'(brk_out), 32'd0);
   endtask

   task automatic run_frame(input logic [1:0] sn, input logic [3:0] bits, input logic dz,
                            input int gap, input bit clr_on_report, input string tag);
      int   n;
      logic err;
      exp_t e;
      n   = model_clamp(sn);
      err = 1'b0;
      en       = 1'b1;
      stop_num = sn;
      for (int i = 0; i < n; i++) begin
         if (bits[i] == 1'b0) err = 1'b1;
         if (i == n - 1) begin
            e.err = err;
            e.brk = dz & err;
            sb.push_back(e);
            send_bit(bits[i], dz);
         end else begin
            send_bit(bits[i], 1'b0);
            check_quiet({tag, "_mid"});
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               check_quiet({tag, "_gap"});
            end
         end
      end
      check_output({tag, "_finish"}, 32'(finish), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_output({tag, "_stp_err"}, 32'(stp_err), 32'(e.err));
         check_output({tag, "_break"}, 32'(brk_out), 32'(e.brk));
         if (clr_on_report) begin
            err_clr    = 1'b1;
            exp_cnt    = 0;
            exp_sticky = 1'b0;
         end else if (e.err) begin
            exp_sticky = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
         end
      end
      @(negedge clk);
      err_clr = 1'b0;
      en      = 1'b0;
      check_quiet({tag, "_after"});
      check_output({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
      check_output({tag, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
   endtask

   initial begin
      #12;
      check_quiet("reset");
      check_output("reset_err_cnt", 32'(err_cnt), 32'd0);
      check_output("reset_sticky", 32'(err_sticky), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_frame(2'd1, 4'b0001, 1'b0, 0, 1'b0, "n1_ok");
      run_frame(2'd2, 4'b0001, 1'b0, 3, 1'b0, "n2_last_bad");
      run_frame(2'd2, 4'b0000, 1'b1, 0, 1'b0, "n2_break");
      run_frame(2'd2, 4'b0010, 1'b1, 1, 1'b0, "n2_first_bad");
      run_frame(2'd3, 4'b0011, 1'b1, 0, 1'b0, "clamp_hi");
      run_frame(2'd0, 4'b0001, 1'b0, 0, 1'b0, "clamp_zero");
      run_frame(2'd2, 4'b0011, 1'b0, 2, 1'b0, "n2_ok");

      // Abort: one strobe, then enable drops before the second stop bit.
      en       = 1'b1;
      stop_num = 2'd2;
      send_bit(1'b0, 1'b0);
      check_quiet("abort_mid");
      en = 1'b0;
      @(negedge clk);
      check_quiet("abort_idle");
      @(negedge clk);
      check_quiet("abort_idle2");
      check_output("abort_err_cnt", 32'(err_cnt), 32'(exp_cnt));
      run_frame(2'd2, 4'b0011, 1'b0, 0, 1'b0, "post_abort");

      while (exp_cnt < 255) begin
         run_frame(2'd1, 4'b0000, 1'b0, 0, 1'b0, "fill");
      end
      run_frame(2'd1, 4'b0000, 1'b0, 0, 1'b0, "sat_hold");
      run_frame(2'd2, 4'b0000, 1'b1, 0, 1'b1, "clr_wins");
      run_frame(2'd1, 4'b0000, 1'b0, 0, 1'b0, "after_clr");

      // Reset in the middle of a two-bit frame.
      en       = 1'b1;
      stop_num = 2'd2;
      send_bit(1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      exp_cnt    = 0;
      exp_sticky = 1'b0;
      check_quiet("midrst");
      check_output("midrst_err_cnt", 32'(err_cnt), 32'd0);
      check_output("midrst_sticky", 32'(err_sticky), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      @(negedge clk);
      check_quiet("midrst_idle");
      run_frame(2'd2, 4'b0001, 1'b0, 0, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
